// File: rtl/fifo_plotter.sv
// fifo_plotter: drains coordinate packets from the mouse-packet FIFO and
// writes the coloured pixel into video memory, with a full-screen clear.
module fifo_plotter #(
  parameter int H_PIX = 640,
  parameter int V_PIX = 480,
  parameter int AW    = 19
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          fifo_empty,
  input  logic [31:0]   FIFO_DOB,
  output logic [8:0]    FIFO_ADDR_OUT,
  input  logic          clear_req,
  input  logic [2:0]    clear_color,
  output logic          vm_req,
  output logic [AW-1:0] vm_addr,
  output logic [2:0]    vm_data,
  input  logic          vm_ack,
  output logic          busy,
  output logic [15:0]   o_plot_count,
  output logic [15:0]   o_drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_WRITE,
    S_CLEAR
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIX * V_PIX - 1);
  localparam logic [9:0]    X_LIM     = 10'(H_PIX);
  localparam logic [9:0]    Y_LIM     = 10'(V_PIX);

  state_t        state, state_nx;
  logic          clr_pend;
  logic [2:0]    clr_color_q;
  logic [2:0]    pkt_color;
  logic [9:0]    pkt_x;
  logic [9:0]    pkt_y;
  logic          in_range;
  logic [AW-1:0] pix_addr;
  logic          unused_dob;

  // Top nine bits of the FIFO word carry no information.
  assign unused_dob = ^FIFO_DOB[31:23];

  // Clip test and linear pixel address of the captured packet
  always_comb begin
    in_range = (pkt_x < X_LIM) && (pkt_y < Y_LIM);
    pix_addr = AW'(pkt_y) * AW'(H_PIX) + AW'(pkt_x);
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a pending clear wins over queued packets
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (clr_pend)         state_nx = S_CLEAR;
        else if (!fifo_empty) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = S_CALC;
      S_CALC:  state_nx = in_range ? S_WRITE : S_IDLE;
      S_WRITE: if (vm_ack) state_nx = S_IDLE;
      S_CLEAR: if (vm_ack && (vm_addr == LAST_ADDR)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode: busy everywhere except IDLE
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath registers: packet capture, read pointer, write port, counters.
  // During CLEAR vm_addr itself serves as the sweep counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FIFO_ADDR_OUT <= '0;
      vm_req        <= 1'b0;
      vm_addr       <= '0;
      vm_data       <= '0;
      o_plot_count  <= '0;
      o_drop_count  <= '0;
      clr_pend      <= 1'b0;
      clr_color_q   <= '0;
      pkt_color     <= '0;
      pkt_x         <= '0;
      pkt_y         <= '0;
    end else begin
      if (clear_req) begin
        clr_pend    <= 1'b1;
        clr_color_q <= clear_color;
      end else if (state == S_IDLE && clr_pend) begin
        clr_pend <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (clr_pend) begin
            vm_addr <= '0;
            vm_data <= clr_color_q;
            vm_req  <= 1'b1;
          end
        end
        S_FETCH: begin
          pkt_color     <= FIFO_DOB[22:20];
          pkt_x         <= FIFO_DOB[19:10];
          pkt_y         <= FIFO_DOB[9:0];
          FIFO_ADDR_OUT <= FIFO_ADDR_OUT + 9'd1;
        end
        S_CALC: begin
          if (in_range) begin
            vm_addr <= pix_addr;
            vm_data <= pkt_color;
            vm_req  <= 1'b1;
          end else begin
            o_drop_count <= o_drop_count + 16'd1;
          end
        end
        S_WRITE: begin
          if (vm_ack) begin
            vm_req       <= 1'b0;
            o_plot_count <= o_plot_count + 16'd1;
          end
        end
        S_CLEAR: begin
          if (vm_ack) begin
            if (vm_addr == LAST_ADDR) vm_req  <= 1'b0;
            else                      vm_addr <= vm_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_plotter.sv
// Directed bench for fifo_plotter at a reduced 160x120 resolution so a full
// clear sweep stays short; a BRAM-style FIFO model feeds the read port.
module tb_fifo_plotter;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int AW = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic          fifo_empty;
  logic [31:0]   FIFO_DOB;
  logic [8:0]    FIFO_ADDR_OUT;
  logic          clear_req;
  logic [2:0]    clear_color;
  logic          vm_req;
  logic [AW-1:0] vm_addr;
  logic [2:0]    vm_data;
  logic          vm_ack;
  logic          busy;
  logic [15:0]   o_plot_count;
  logic [15:0]   o_drop_count;

  logic [31:0]   mem [512];
  logic [8:0]    wp;
  logic [AW+2:0] wr_q [$];

  int checks = 0;
  int errors = 0;

  fifo_plotter #(.H_PIX(H), .V_PIX(V), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .fifo_empty(fifo_empty), .FIFO_DOB(FIFO_DOB),
    .FIFO_ADDR_OUT(FIFO_ADDR_OUT), .clear_req(clear_req), .clear_color(clear_color),
    .vm_req(vm_req), .vm_addr(vm_addr), .vm_data(vm_data), .vm_ack(vm_ack),
    .busy(busy), .o_plot_count(o_plot_count), .o_drop_count(o_drop_count)
  );

  always #5 CLK = ~CLK;

  assign fifo_empty = (FIFO_ADDR_OUT == wp);

  always @(posedge CLK) FIFO_DOB <= mem[FIFO_ADDR_OUT];

  always @(posedge CLK) if (!RST && vm_req && vm_ack) wr_q.push_back({vm_addr, vm_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [9:0] x, input logic [9:0] y);
    mem[wp] = {9'b0, c, x, y};
    wp = wp + 9'd1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n = 0;
    while (vm_req !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(vm_req), 32'd1);
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_q.size() < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(wr_q.size()), 32'(target));
  endtask

  initial begin
    int base;
    int bad;
    logic [AW+2:0] e;

    RST = 1'b1; vm_ack = 1'b0; clear_req = 1'b0; clear_color = '0; wp = '0;
    step(2);
    chk("rst_ptr", 32'(FIFO_ADDR_OUT), 0);
    chk("rst_req", 32'(vm_req), 0);
    chk("rst_addr", 32'(vm_addr), 0);
    chk("rst_data", 32'(vm_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_plot", 32'(o_plot_count), 0);
    chk("rst_drop", 32'(o_drop_count), 0);
    RST = 1'b0;
    step(1);

    // single packet, ack high: request on the third edge, one cycle long
    vm_ack = 1'b1;
    push(3'd5, 10'd100, 10'd50);
    step(1);
    chk("p1_busy", 32'(busy), 1);
    chk("p1_req_early1", 32'(vm_req), 0);
    step(1);
    chk("p1_req_early2", 32'(vm_req), 0);
    step(1);
    chk("p1_req", 32'(vm_req), 1);
    chk("p1_addr", 32'(vm_addr), 8100);
    chk("p1_data", 32'(vm_data), 5);
    chk("p1_ptr", 32'(FIFO_ADDR_OUT), 1);
    chk("p1_empty", 32'(fifo_empty), 1);
    step(1);
    chk("p1_req_done", 32'(vm_req), 0);
    chk("p1_plot", 32'(o_plot_count), 1);
    chk("p1_idle", 32'(busy), 0);

    // clipped packets on x and on y
    push(3'd1, 10'd160, 10'd10);
    push(3'd2, 10'd10, 10'd120);
    step(10);
    chk("drop_cnt", 32'(o_drop_count), 2);
    chk("drop_ptr", 32'(FIFO_ADDR_OUT), 3);
    chk("drop_nowr", 32'(wr_q.size()), 1);
    chk("drop_plot", 32'(o_plot_count), 1);

    // bottom-right corner pixel
    push(3'd7, 10'd159, 10'd119);
    wait_wr(2, 20, "corner_wr");
    chk("corner_px", 32'(wr_q[1]), 32'({15'd19199, 3'd7}));
    step(1);

    // stalled acknowledge: request held stable
    vm_ack = 1'b0;
    push(3'd3, 10'd1, 10'd2);
    wait_req(10, "stall_req_up");
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", 32'(vm_req), 1);
      chk("stall_addr", 32'(vm_addr), 321);
      chk("stall_data", 32'(vm_data), 3);
      step(1);
    end
    chk("stall_plot", 32'(o_plot_count), 2);
    vm_ack = 1'b1;
    step(1);
    chk("stall_req_done", 32'(vm_req), 0);
    chk("stall_plot_done", 32'(o_plot_count), 3);

    // clear requested while a packet waits in WRITE, more packets queued
    vm_ack = 1'b0;
    push(3'd6, 10'd5, 10'd5);
    wait_req(10, "clr_pkt_req");
    chk("clr_pkt_addr", 32'(vm_addr), 805);
    push(3'd4, 10'd0, 10'd0);
    push(3'd1, 10'd159, 10'd0);
    clear_req = 1'b1; clear_color = 3'd3;
    step(1);
    clear_color = 3'd0;
    step(1);
    clear_req = 1'b0;
    base = wr_q.size();
    vm_ack = 1'b1;
    wait_wr(base + 1 + H * V + 2, 25000, "clr_wr_total");
    if (wr_q.size() >= base + 1 + H * V + 2) begin
      chk("clr_first_pkt", 32'(wr_q[base]), 32'({15'd805, 3'd6}));
      bad = 0;
      for (int i = 0; i < H * V; i++) begin
        e = {AW'(i), 3'd0};
        if (wr_q[base + 1 + i] !== e) bad++;
      end
      chk("clr_sweep_bad", 32'(bad), 0);
      chk("clr_drain1", 32'(wr_q[base + 1 + H * V]), 32'({15'd0, 3'd4}));
      chk("clr_drain2", 32'(wr_q[base + 2 + H * V]), 32'({15'd159, 3'd1}));
    end
    step(20);
    chk("clr_no_repeat", 32'(wr_q.size()), 32'(base + 3 + H * V));
    chk("clr_busy", 32'(busy), 0);
    chk("clr_plot", 32'(o_plot_count), 6);
    chk("clr_drop", 32'(o_drop_count), 2);
    chk("clr_ptr", 32'(FIFO_ADDR_OUT), 8);
    chk("clr_empty", 32'(fifo_empty), 1);

    // 512 back-to-back packets from a fresh reset: pointer wraps to 0
    RST = 1'b1; wp = '0;
    step(1);
    RST = 1'b0;
    step(1);
    chk("r2_plot", 32'(o_plot_count), 0);
    chk("r2_drop", 32'(o_drop_count), 0);
    chk("r2_ptr", 32'(FIFO_ADDR_OUT), 0);
    wr_q.delete();
    vm_ack = 1'b1;
    for (int i = 0; i < 512; i++) begin
      push(3'(i % 8), 10'(i % H), 10'(i / H));
      step(1);
    end
    wait_wr(512, 3000, "burst_wr");
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < 512; i++) begin
      e = {AW'(i), 3'(i % 8)};
      if (wr_q[i] !== e) bad++;
    end
    chk("burst_order_bad", 32'(bad), 0);
    step(5);
    chk("burst_ptr", 32'(FIFO_ADDR_OUT), 0);
    chk("burst_empty", 32'(fifo_empty), 1);
    chk("burst_plot", 32'(o_plot_count), 512);
    chk("burst_busy", 32'(busy), 0);

    // reset in WRITE: outputs drop before any clock edge
    vm_ack = 1'b0;
    push(3'd2, 10'd3, 10'd4);
    wait_req(10, "r3_req_up");
    chk("r3_ptr_pre", 32'(FIFO_ADDR_OUT), 1);
    RST = 1'b1;
    #1;
    chk("r3_req_async", 32'(vm_req), 0);
    chk("r3_ptr_async", 32'(FIFO_ADDR_OUT), 0);
    chk("r3_busy_async", 32'(busy), 0);
    wp = '0;
    @(negedge CLK);
    RST = 1'b0;
    step(1);
    chk("r3_busy", 32'(busy), 0);
    chk("r3_plot", 32'(o_plot_count), 0);
    chk("r3_drop", 32'(o_drop_count), 0);
    vm_ack = 1'b1;
    step(5);
    chk("r3_req_quiet", 32'(vm_req), 0);
    chk("r3_empty", 32'(fifo_empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
